dmem_responder: RTL and testbench

- Data-memory responder for the MIPS single-cycle core's data port (memwrite, memread, dataadr, writedata → readdata).
- Sits at the far end of that interface, in place of a zero-latency combinational RAM.
- Adds a registered ready handshake with configurable wait states, plus alignment/range error flagging.
- Keeps a write counter and a last-write capture so benches and debug logic can observe stores without probing the core.

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_ram.sv | 25 ++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, word width,
// and the address legality check reusable by the instruction-memory side.
package dmem_responder_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the byte address is word aligned and falls inside a memory of depth_words words.
  function automatic logic adr_ok(input logic [63:0] adr, input int unsigned depth_words);
    return (adr[1:0] == 2'b00) && (adr < (64'(depth_words) * 64'd4));
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTH x 32 word memory: synchronous write, registered read.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: registered ready handshake
// with wait states, alignment/range/conflict rejection, and store observation.
//
// state | meaning
// IDLE  | waiting for memwrite/memread; latches the request on accept
// WAIT  | stalling; wait_cnt counts down to zero
// RESP  | one-cycle completion; RAM access, ready/err registered
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [AW-1:0]     dataadr,
  input  logic [WORD_W-1:0] writedata,
  output logic [WORD_W-1:0] readdata,
  output logic              ready,
  output logic              err,
  output logic [31:0]       wr_count,
  output logic [AW-1:0]     last_wr_adr,
  output logic [WORD_W-1:0] last_wr_data
);

  localparam int IW = $clog2(DEPTH);

  state_t            state;
  logic [31:0]       wait_cnt;
  logic [AW-1:0]     adr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              we_q;
  logic              bad_q;
  logic              rd_valid;
  logic              req;
  logic              req_bad;
  logic              ram_en;
  logic [WORD_W-1:0] ram_q;

  assign req     = memwrite | memread;
  assign req_bad = !adr_ok(64'(dataadr), DEPTH) || (memwrite && memread);

  // Gate on reset so an aborted RESP cycle never commits a store.
  assign ram_en  = (state == RESP) && !bad_q && !reset;

  dmem_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_q),
    .addr  (adr_q[IW+1:2]),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  // The RAM output register holds across writes, so a flag decides whether it is shown.
  assign readdata = rd_valid ? ram_q : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ready        <= 1'b0;
      err          <= 1'b0;
      rd_valid     <= 1'b0;
      wait_cnt     <= '0;
      wr_count     <= '0;
      last_wr_adr  <= '0;
      last_wr_data <= '0;
      adr_q        <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      bad_q        <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            adr_q   <= dataadr;
            wdata_q <= writedata;
            we_q    <= memwrite;
            bad_q   <= req_bad;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= 32'(WAIT_CYCLES - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) state <= RESP;
          else                wait_cnt <= wait_cnt - 32'd1;
        end
        RESP: begin
          ready <= 1'b1;
          err   <= bad_q;
          state <= IDLE;
          if (bad_q) begin
            rd_valid <= 1'b0;
          end else if (we_q) begin
            if (wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
            last_wr_adr  <= adr_q;
            last_wr_data <= wdata_q;
          end else begin
            rd_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states and 0 wait states)
// checked every cycle against a transaction-latency model, plus literal pins.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       reset;
  logic [1:0]       memwrite;
  logic [1:0]       memread;
  logic [1:0][31:0] dataadr;
  logic [1:0][31:0] writedata;
  logic [1:0][31:0] readdata;
  logic [1:0]       ready;
  logic [1:0]       err;
  logic [1:0][31:0] wr_count;
  logic [1:0][31:0] last_wr_adr;
  logic [1:0][31:0] last_wr_data;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .AW(32)) dut0 (
    .clk(clk), .reset(reset[0]), .memwrite(memwrite[0]), .memread(memread[0]),
    .dataadr(dataadr[0]), .writedata(writedata[0]), .readdata(readdata[0]),
    .ready(ready[0]), .err(err[0]), .wr_count(wr_count[0]),
    .last_wr_adr(last_wr_adr[0]), .last_wr_data(last_wr_data[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .AW(32)) dut1 (
    .clk(clk), .reset(reset[1]), .memwrite(memwrite[1]), .memread(memread[1]),
    .dataadr(dataadr[1]), .writedata(writedata[1]), .readdata(readdata[1]),
    .ready(ready[1]), .err(err[1]), .wr_count(wr_count[1]),
    .last_wr_adr(last_wr_adr[1]), .last_wr_data(last_wr_data[1])
  );

  // Model state: one pending transaction per instance, completing WAIT+1 edges after accept.
  int          cyc;
  bit          pend [2];
  int          acc [2];
  bit          p_we [2];
  bit          p_re [2];
  logic [31:0] p_adr [2];
  logic [31:0] p_d [2];
  bit          exp_ready [2];
  bit          exp_err [2];
  bit          exp_rd_known [2];
  logic [31:0] exp_rd [2];
  logic [31:0] m_wc [2];
  logic [31:0] m_la [2];
  logic [31:0] m_ld [2];
  logic [31:0] mem [2][DEPTH];
  bit          mknown [2][DEPTH];
  int          ready_seen [2];
  int          checks;
  int          failures;

  function automatic int wcyc(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      exp_ready[i] = 1'b0;
      if (reset[i]) begin
        pend[i] = 1'b0;
        m_wc[i] = '0;
        m_la[i] = '0;
        m_ld[i] = '0;
      end else if (pend[i] && cyc == acc[i] + wcyc(i) + 1) begin
        pend[i]         = 1'b0;
        exp_ready[i]    = 1'b1;
        exp_rd_known[i] = 1'b0;
        exp_err[i] = (p_adr[i] % 4 != 0) || (p_adr[i] >= 4 * DEPTH) || (p_we[i] && p_re[i]);
        if (!exp_err[i]) begin
          if (p_we[i]) begin
            mem[i][p_adr[i] / 4]    = p_d[i];
            mknown[i][p_adr[i] / 4] = 1'b1;
            if (m_wc[i] != 32'hFFFF_FFFF) m_wc[i] = m_wc[i] + 1;
            m_la[i] = p_adr[i];
            m_ld[i] = p_d[i];
          end else begin
            exp_rd[i]       = mem[i][p_adr[i] / 4];
            exp_rd_known[i] = mknown[i][p_adr[i] / 4];
          end
        end
      end else if (!pend[i] && (memwrite[i] || memread[i])) begin
        pend[i]  = 1'b1;
        acc[i]   = cyc;
        p_we[i]  = memwrite[i];
        p_re[i]  = memread[i];
        p_adr[i] = dataadr[i];
        p_d[i]   = writedata[i];
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      if (ready[i]) ready_seen[i]++;
      chk($sformatf("dut%0d.ready", i), 32'(ready[i]), 32'(exp_ready[i]));
      if (exp_ready[i]) begin
        chk($sformatf("dut%0d.err", i), 32'(err[i]), 32'(exp_err[i]));
        if (exp_err[i])
          chk($sformatf("dut%0d.readdata_on_err", i), readdata[i], 32'h0);
        else if (!p_we[i] && exp_rd_known[i])
          chk($sformatf("dut%0d.readdata", i), readdata[i], exp_rd[i]);
      end
      chk($sformatf("dut%0d.wr_count", i), wr_count[i], m_wc[i]);
      chk($sformatf("dut%0d.last_wr_adr", i), last_wr_adr[i], m_la[i]);
      chk($sformatf("dut%0d.last_wr_data", i), last_wr_data[i], m_ld[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic do_req(input int i, input bit we, input bit re, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output bit e,
                        output logic [31:0] rd);
    int  n;
    bit  done;
    memwrite[i]  = we;
    memread[i]   = re;
    dataadr[i]   = a;
    writedata[i] = d;
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (ready[i]) done = 1'b1;
    end
    if (!done) begin
      failures++;
      $display("FAIL dut%0d.ready_timeout actual=none required=pulse within 20 cycles", i);
    end
    lat = n - 1;
    e   = err[i];
    rd  = readdata[i];
    memwrite[i] = 1'b0;
    memread[i]  = 1'b0;
  endtask

  int          lat;
  bit          e;
  logic [31:0] rd;
  int          rs;
  int          t_first;
  int          t_second;
  int          nreq;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; acc[i] = 0; m_wc[i] = 0; m_la[i] = 0; m_ld[i] = 0;
      exp_ready[i] = 0; exp_err[i] = 0; exp_rd_known[i] = 0; exp_rd[i] = 0;
      ready_seen[i] = 0; p_we[i] = 0; p_re[i] = 0; p_adr[i] = 0; p_d[i] = 0;
      for (int k = 0; k < DEPTH; k++) begin mem[i][k] = '0; mknown[i][k] = 0; end
    end
    memwrite = '0; memread = '0; dataadr = '0; writedata = '0;
    reset = 2'b11;
    tick();
    tick();
    reset = 2'b00;
    chk("reset.wr_count", wr_count[0], 32'd0);
    chk("reset.readdata", readdata[0], 32'd0);
    chk("reset.ready", 32'(ready[0]), 32'd0);

    // Store 7 to 84, load it back.
    do_req(0, 1, 0, 32'd84, 32'd7, lat, e, rd);
    chk("st84.latency", 32'(lat), 32'd3);
    chk("st84.err", 32'(e), 32'd0);
    do_req(0, 0, 1, 32'd84, 32'd0, lat, e, rd);
    chk("ld84.latency", 32'(lat), 32'd3);
    chk("ld84.readdata", rd, 32'd7);
    chk("ld84.wr_count", wr_count[0], 32'd1);
    chk("ld84.last_wr_adr", last_wr_adr[0], 32'd84);
    chk("ld84.last_wr_data", last_wr_data[0], 32'd7);

    do_req(0, 1, 0, 32'd80, 32'h1111, lat, e, rd);
    do_req(0, 1, 0, 32'd0, 32'hA5, lat, e, rd);

    // Misaligned store is rejected without side effects.
    do_req(0, 1, 0, 32'd82, 32'hDEAD, lat, e, rd);
    chk("st82.err", 32'(e), 32'd1);
    chk("st82.wr_count", wr_count[0], 32'd3);
    do_req(0, 0, 1, 32'd80, 32'd0, lat, e, rd);
    chk("ld80_after_misalign", rd, 32'h1111);

    // Out-of-range store must not alias onto word 0.
    do_req(0, 1, 0, 32'd256, 32'hBEEF, lat, e, rd);
    chk("st256.err", 32'(e), 32'd1);
    do_req(0, 0, 1, 32'd0, 32'd0, lat, e, rd);
    chk("ld0_after_oor", rd, 32'hA5);

    // Simultaneous read and write.
    do_req(0, 1, 1, 32'd80, 32'h5555, lat, e, rd);
    chk("conflict.err", 32'(e), 32'd1);
    chk("conflict.readdata", rd, 32'd0);
    do_req(0, 0, 1, 32'd80, 32'd0, lat, e, rd);
    chk("ld80_after_conflict", rd, 32'h1111);

    // Reset in the second WAIT cycle of a store of 5 to 80.
    memwrite[0] = 1'b1; dataadr[0] = 32'd80; writedata[0] = 32'd5;
    tick();
    tick();
    reset[0] = 1'b1;
    memwrite[0] = 1'b0;
    rs = ready_seen[0];
    tick();
    reset[0] = 1'b0;
    tick();
    chk("abort.ready_pulses", 32'(ready_seen[0] - rs), 32'd0);
    chk("abort.wr_count", wr_count[0], 32'd0);
    do_req(0, 0, 1, 32'd80, 32'd0, lat, e, rd);
    chk("abort.ld80", rd, 32'h1111);
    chk("abort.ld80_latency", 32'(lat), 32'd3);

    // Zero wait states, requests held continuously: 80 then 84.
    memwrite[1] = 1'b1; dataadr[1] = 32'd80; writedata[1] = 32'h80;
    t_first = 0; t_second = 0; nreq = 0;
    for (int n = 1; n <= 10 && nreq < 2; n++) begin
      tick();
      if (ready[1]) begin
        nreq++;
        if (nreq == 1) begin
          t_first = n;
          dataadr[1] = 32'd84; writedata[1] = 32'h84;
        end else begin
          t_second = n;
          memwrite[1] = 1'b0;
        end
      end
    end
    memwrite[1] = 1'b0;
    chk("w0.responses", 32'(nreq), 32'd2);
    chk("w0.first_ready", 32'(t_first), 32'd2);
    chk("w0.ready_spacing", 32'(t_second - t_first), 32'd2);
    chk("w0.wr_count", wr_count[1], 32'd2);
    chk("w0.last_wr_adr", last_wr_adr[1], 32'd84);
    chk("w0.last_wr_data", last_wr_data[1], 32'h84);
    do_req(1, 0, 1, 32'd80, 32'd0, lat, e, rd);
    chk("w0.ld80_latency", 32'(lat), 32'd1);
    chk("w0.ld80", rd, 32'h80);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
